// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format codes and RV64 opcode constants.
// Shared by imm_gen_decode and imm_gen_pipe; IMM_GEN_ZIMM_EN enables format Z.
package imm_gen_pkg;

    localparam int IMM_FMT_W = 3;

    typedef enum logic [IMM_FMT_W-1:0] {
        IMM_FMT_NONE = 3'd0,
        IMM_FMT_I    = 3'd1,
        IMM_FMT_S    = 3'd2,
        IMM_FMT_B    = 3'd3,
        IMM_FMT_U    = 3'd4,
        IMM_FMT_J    = 3'd5,
        IMM_FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/imm_gen_decode.sv
// imm_gen_decode: combinational instr -> sign-extended immediate and format.
// Macro IMM_GEN_ZIMM_EN adds the CSR*I zero-extended uimm format.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            unknown
);

    logic [6:0] opc;
    logic is_i, is_s, is_b, is_u, is_j, is_z;
    logic unused_bits;

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign opc = instr[6:0];

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef IMM_GEN_ZIMM_EN
    assign is_z = (opc == OPC_SYSTEM) && instr[14];
`else
    assign is_z = 1'b0;
`endif

    assign is_i = !is_z && (opc inside {OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
                                        OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM});
    assign is_s = (opc == OPC_STORE);
    assign is_b = (opc == OPC_BRANCH);
    assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
    assign is_j = (opc == OPC_JAL);

    assign unused_bits = &{1'b0, instr[14:12]};

    // Signed size casts replicate instr[31] up to XLEN.
    always_comb begin
        imm     = '0;
        fmt     = IMM_FMT_NONE;
        unknown = 1'b0;
        unique case (1'b1)
            is_z: begin
                imm = XLEN'(instr[19:15]);
                fmt = IMM_FMT_Z;
            end
            is_i: begin
                imm = XLEN'(imm_i);
                fmt = IMM_FMT_I;
            end
            is_s: begin
                imm = XLEN'(imm_s);
                fmt = IMM_FMT_S;
            end
            is_b: begin
                imm = XLEN'(imm_b);
                fmt = IMM_FMT_B;
            end
            is_u: begin
                imm = XLEN'(imm_u);
                fmt = IMM_FMT_U;
            end
            is_j: begin
                imm = XLEN'(imm_j);
                fmt = IMM_FMT_J;
            end
            default: begin
                unknown = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer.
// Optional Z format (CSR*I uimm) is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [IMM_FMT_W-1:0] out_fmt,
    output logic                 out_unknown,
    output logic [TAG_W-1:0]     out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             unknown;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_unk;
    entry_t          new_e;
    entry_t          out_q;
    entry_t          skid_q;
    logic            out_v_q;
    logic            skid_v_q;
    logic            accept;
    logic            drain;

    imm_gen_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .unknown (dec_unk)
    );

    assign new_e = '{imm: dec_imm, fmt: dec_fmt,
                     unknown: dec_unk, tag: in_tag};

    // in_ready depends only on registered state.
    assign in_ready = !skid_v_q;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_v_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (!out_v_q || drain) begin
            if (skid_v_q) begin
                out_q    <= skid_q;
                out_v_q  <= 1'b1;
                skid_v_q <= 1'b0;
            end else begin
                out_v_q <= accept;
                if (accept) out_q <= new_e;
            end
        end else if (accept) begin
            skid_q   <= new_e;
            skid_v_q <= 1'b1;
        end
    end

    assign out_valid   = out_v_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_unknown = out_q.unknown;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors for imm_gen_pipe (XLEN=64, TAG_W=8).
// Checks decode formats, skid backpressure, flush and async reset.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_unknown;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_unknown (out_unknown),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic unk,
                           input logic [7:0] t);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".imm"}, out_imm, imm);
        chk({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        chk({tag, ".unk"}, 64'(out_unknown), 64'(unk));
        chk({tag, ".tag"}, 64'(out_tag), 64'(t));
    endtask

    task automatic send(input logic [31:0] instr, input logic [7:0] t);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.imm", out_imm, 64'd0);
        chk("rst.fmt", 64'(out_fmt), 64'd0);
        chk("rst.unk", 64'(out_unknown), 64'd0);
        chk("rst.tag", 64'(out_tag), 64'd0);
        chk("rst.ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(32'hFFF0_0093, 8'd1);
        chk_out("addi", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 8'd1);
        send(32'h8000_0063, 8'd2);
        chk_out("beq", 64'hFFFF_FFFF_FFFF_F000, 3'd3, 1'b0, 8'd2);
        send(32'h8000_0037, 8'd3);
        chk_out("lui", 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 8'd3);
        send(32'h0040_006F, 8'd4);
        chk_out("jal", 64'd4, 3'd5, 1'b0, 8'd4);
        send(32'hFE11_2E23, 8'd5);
        chk_out("sw", 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 8'd5);
        send(32'h0000_007F, 8'd6);
        chk_out("unk", 64'd0, 3'd0, 1'b1, 8'd6);
`ifdef IMM_GEN_ZIMM_EN
        send(32'h3400_D073, 8'd7);
        chk_out("csrrwi", 64'd1, 3'd6, 1'b0, 8'd7);
`else
        send(32'h3400_D073, 8'd7);
        chk_out("csrrwi", 64'h340, 3'd1, 1'b0, 8'd7);
`endif
        tick();
        chk("idle.valid", 64'(out_valid), 64'd0);

        in_valid = 1'b1;
        in_instr = 32'h0010_0093;
        in_tag   = 8'd10;
        tick();
        in_instr  = 32'h0020_0093;
        in_tag    = 8'd11;
        out_ready = 1'b0;
        tick();
        chk("bp.ready0", 64'(in_ready), 64'd0);
        in_instr = 32'h0030_0093;
        in_tag   = 8'd12;
        tick();
        chk_out("bp.hold", 64'd1, 3'd1, 1'b0, 8'd10);
        chk("bp.ready1", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk_out("bp.b", 64'd2, 3'd1, 1'b0, 8'd11);
        chk("bp.ready2", 64'(in_ready), 64'd1);
        tick();
        chk_out("bp.c", 64'd3, 3'd1, 1'b0, 8'd12);
        in_instr = 32'h0040_0093;
        in_tag   = 8'd13;
        tick();
        in_valid = 1'b0;
        chk_out("bp.d", 64'd4, 3'd1, 1'b0, 8'd13);
        tick();
        chk("bp.empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(32'h0050_0093, 8'd20);
        send(32'h0060_0093, 8'd21);
        chk("fl.full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h0070_0093;
        in_tag   = 8'd22;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.valid", 64'(out_valid), 64'd0);
        chk("fl.ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("fl.gone", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(32'h0080_0093, 8'd30);
        in_valid = 1'b1;
        in_instr = 32'h0090_0093;
        in_tag   = 8'd31;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("fl2.drop", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(32'h00A0_0093, 8'd40);
        send(32'h00B0_0093, 8'd41);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 64'(out_valid), 64'd0);
        chk("mrst.ready", 64'(in_ready), 64'd1);
        chk("mrst.imm", out_imm, 64'd0);
        chk("mrst.tag", 64'(out_tag), 64'd0);
        chk("mrst.fmt", 64'(out_fmt), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("post.valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
